stack_sequencer: RTL and testbench

- Multi-cycle controller for every stack transfer done by control-flow instructions: CALL, INT, RET and RTI.
- Owns the stack pointer and drives the 16-bit data memory port.
- Splits the 32-bit PC into hi/lo words and the 3-bit flags into one word. On pops it reassembles them and issues load pulses to the PC and flag registers.
- Sits beside the memory stage. Its `busy` output stalls the pipeline while a sequence runs.

---
 rtl/stack_sequencer_if.sv | 36 +++
 rtl/stack_sequencer.sv | 154 +++++++++++++++
 tb/tb_stack_sequencer.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_sequencer_if.sv
// Stack-sequencer bus: request side, memory port and pop results.
interface stack_sequencer_if #(
  parameter int SP_W = 32
);
  logic            start;
  logic [1:0]      op;
  logic [31:0]     pc_in;
  logic [2:0]      flags_in;
  logic [15:0]     mem_rdata;
  logic            mem_rd;
  logic            mem_wr;
  logic [SP_W-1:0] mem_addr;
  logic [15:0]     mem_wdata;
  logic [SP_W-1:0] sp;
  logic            busy;
  logic [1:0]      step;
  logic [31:0]     pc_out;
  logic            pc_load;
  logic [2:0]      flags_out;
  logic            flags_load;
  logic            done;

  // Requester plus memory side: issues requests, returns read data.
  modport master (
    output start, op, pc_in, flags_in, mem_rdata,
    input  mem_rd, mem_wr, mem_addr, mem_wdata, sp, busy, step,
    input  pc_out, pc_load, flags_out, flags_load, done
  );

  // Sequencer side.
  modport slave (
    input  start, op, pc_in, flags_in, mem_rdata,
    output mem_rd, mem_wr, mem_addr, mem_wdata, sp, busy, step,
    output pc_out, pc_load, flags_out, flags_load, done
  );
endinterface

// File: rtl/stack_sequencer.sv
// Stack sequencer: runs the push/pop word sequences for CALL, INT, RET and
// RTI, owns the stack pointer and drives the 16-bit data memory port.
module stack_sequencer #(
  parameter int              SP_W    = 32,
  parameter logic [SP_W-1:0] SP_INIT = 32'h000F_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  stack_sequencer_if.slave  bus
);

  localparam logic [1:0] OP_CALL = 2'b00;
  localparam logic [1:0] OP_INT  = 2'b01;
  localparam logic [1:0] OP_RTI  = 2'b11;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_PUSH_F = 4'd1;
  localparam logic [3:0] S_PUSH_H = 4'd2;
  localparam logic [3:0] S_PUSH_L = 4'd3;
  localparam logic [3:0] S_POP_L  = 4'd4;
  localparam logic [3:0] S_POP_H  = 4'd5;
  localparam logic [3:0] S_POP_F  = 4'd6;
  localparam logic [3:0] S_CAP    = 4'd7;
  localparam logic [3:0] S_FIN    = 4'd8;

  logic [3:0]      state_q, state_d;
  logic [SP_W-1:0] sp_q, sp_d;
  logic [1:0]      op_q, op_d;
  logic [31:0]     pc_q, pc_d;
  logic [2:0]      flags_q, flags_d;
  logic [31:0]     pc_out_q, pc_out_d;
  logic [2:0]      flags_out_q, flags_out_d;

  logic            is_push;
  logic            is_pop;

  assign is_push = (state_q == S_PUSH_F) || (state_q == S_PUSH_H) || (state_q == S_PUSH_L);
  assign is_pop  = (state_q == S_POP_L)  || (state_q == S_POP_H)  || (state_q == S_POP_F);

  // Next-state, stack pointer and capture logic.
  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    op_d        = op_q;
    pc_d        = pc_q;
    flags_d     = flags_q;
    pc_out_d    = pc_out_q;
    flags_out_d = flags_out_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          pc_d    = bus.pc_in;
          flags_d = bus.flags_in;
          if (bus.op == OP_CALL)     state_d = S_PUSH_H;
          else if (bus.op == OP_INT) state_d = S_PUSH_F;
          else                       state_d = S_POP_L;
        end
      end
      S_PUSH_F: begin
        sp_d    = sp_q - SP_W'(1);
        state_d = S_PUSH_H;
      end
      S_PUSH_H: begin
        sp_d    = sp_q - SP_W'(1);
        state_d = S_PUSH_L;
      end
      S_PUSH_L: begin
        sp_d    = sp_q - SP_W'(1);
        state_d = S_FIN;
      end
      S_POP_L: begin
        sp_d    = sp_q + SP_W'(1);
        state_d = S_POP_H;
      end
      S_POP_H: begin
        // Read data here is the low PC word fetched during POP_L.
        sp_d     = sp_q + SP_W'(1);
        pc_out_d = {pc_out_q[31:16], bus.mem_rdata};
        state_d  = (op_q == OP_RTI) ? S_POP_F : S_CAP;
      end
      S_POP_F: begin
        sp_d     = sp_q + SP_W'(1);
        pc_out_d = {bus.mem_rdata, pc_out_q[15:0]};
        state_d  = S_CAP;
      end
      S_CAP: begin
        // Last read returns the high PC word (RET) or the flags word (RTI).
        if (op_q == OP_RTI) flags_out_d = bus.mem_rdata[2:0];
        else                pc_out_d    = {bus.mem_rdata, pc_out_q[15:0]};
        state_d = S_FIN;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sp_q        <= SP_INIT;
      op_q        <= 2'b00;
      pc_q        <= 32'h0;
      flags_q     <= 3'b000;
      pc_out_q    <= 32'h0;
      flags_out_q <= 3'b000;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      op_q        <= op_d;
      pc_q        <= pc_d;
      flags_q     <= flags_d;
      pc_out_q    <= pc_out_d;
      flags_out_q <= flags_out_d;
    end
  end

  // Memory port, status and pulse decode from the current state.
  always_comb begin
    bus.mem_wdata = 16'h0000;
    bus.step      = 2'd0;
    case (state_q)
      S_PUSH_F: begin
        bus.mem_wdata = {13'b0, flags_q};
        bus.step      = 2'd3;
      end
      S_PUSH_H: begin
        bus.mem_wdata = pc_q[31:16];
        bus.step      = 2'd2;
      end
      S_PUSH_L: begin
        bus.mem_wdata = pc_q[15:0];
        bus.step      = 2'd1;
      end
      S_POP_L:  bus.step = (op_q == OP_RTI) ? 2'd3 : 2'd2;
      S_POP_H:  bus.step = (op_q == OP_RTI) ? 2'd2 : 2'd1;
      S_POP_F:  bus.step = 2'd1;
      default:  bus.step = 2'd0;
    endcase
  end

  assign bus.mem_wr     = is_push;
  assign bus.mem_rd     = is_pop;
  assign bus.mem_addr   = is_pop ? (sp_q + SP_W'(1)) : sp_q;
  assign bus.sp         = sp_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_FIN);
  assign bus.pc_load    = (state_q == S_FIN) && op_q[1];
  assign bus.flags_load = (state_q == S_FIN) && (op_q == OP_RTI);
  assign bus.pc_out     = pc_out_q;
  assign bus.flags_out  = flags_out_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Directed bench for stack_sequencer: CALL/RET, INT/RTI, ignored start,
// mid-sequence reset and stack pointer wrap.
module tb_stack_sequencer;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  stack_sequencer_if #(.SP_W(32)) ifa ();
  stack_sequencer_if #(.SP_W(32)) ifb ();

  stack_sequencer #(.SP_W(32), .SP_INIT(32'h000F_FFFF)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (ifa)
  );

  stack_sequencer #(.SP_W(32), .SP_INIT(32'h0000_0000)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (ifb)
  );

  // Word memories with one-cycle registered read, indexed by low address bits.
  logic [15:0] mem_a [16];
  logic [15:0] mem_b [16];

  // Memory model for instance A.
  always @(posedge clk) begin
    if (rst_a) begin
      for (int i = 0; i < 16; i++) mem_a[i] <= 16'h0;
      ifa.mem_rdata <= 16'h0;
    end else begin
      if (ifa.mem_wr) mem_a[ifa.mem_addr[3:0]] <= ifa.mem_wdata;
      if (ifa.mem_rd) ifa.mem_rdata <= mem_a[ifa.mem_addr[3:0]];
    end
  end

  // Memory model for instance B.
  always @(posedge clk) begin
    if (rst_b) begin
      for (int i = 0; i < 16; i++) mem_b[i] <= 16'h0;
      ifb.mem_rdata <= 16'h0;
    end else begin
      if (ifb.mem_wr) mem_b[ifb.mem_addr[3:0]] <= ifb.mem_wdata;
      if (ifb.mem_rd) ifb.mem_rdata <= mem_b[ifb.mem_addr[3:0]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic go_a(input logic [1:0] o, input logic [31:0] p, input logic [2:0] f);
    ifa.start    = 1'b1;
    ifa.op       = o;
    ifa.pc_in    = p;
    ifa.flags_in = f;
    tick();
    ifa.start = 1'b0;
  endtask

  task automatic go_b(input logic [1:0] o, input logic [31:0] p);
    ifb.start    = 1'b1;
    ifb.op       = o;
    ifb.pc_in    = p;
    ifb.flags_in = 3'b000;
    tick();
    ifb.start = 1'b0;
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    ifa.start = 1'b0; ifa.op = 2'b00; ifa.pc_in = 32'h0; ifa.flags_in = 3'b000;
    ifb.start = 1'b0; ifb.op = 2'b00; ifb.pc_in = 32'h0; ifb.flags_in = 3'b000;
    tick();
    tick();

    // Reset state
    chk("rst_sp",       ifa.sp,        32'h000F_FFFF);
    chk("rst_busy",     ifa.busy,      32'd0);
    chk("rst_step",     ifa.step,      32'd0);
    chk("rst_pc_out",   ifa.pc_out,    32'h0);
    chk("rst_flags",    ifa.flags_out, 32'h0);
    chk("rst_strobes",  {ifa.mem_rd, ifa.mem_wr, ifa.done, ifa.pc_load, ifa.flags_load}, 32'h0);
    chk("rst_addr",     ifa.mem_addr,  32'h000F_FFFF);
    chk("rst_wdata",    ifa.mem_wdata, 32'h0);
    rst_a = 1'b0;
    tick();

    // CALL 0001_2345 from reset
    go_a(2'b00, 32'h0001_2345, 3'b000);
    chk("call_c1_wr",    {ifa.mem_rd, ifa.mem_wr, ifa.busy}, 32'b011);
    chk("call_c1_step",  ifa.step,      32'd2);
    chk("call_c1_addr",  ifa.mem_addr,  32'h000F_FFFF);
    chk("call_c1_wdata", ifa.mem_wdata, 32'h0001);
    tick();
    chk("call_c2_step",  ifa.step,      32'd1);
    chk("call_c2_addr",  ifa.mem_addr,  32'h000F_FFFE);
    chk("call_c2_wdata", ifa.mem_wdata, 32'h2345);
    tick();
    chk("call_c3_done",  {ifa.done, ifa.pc_load, ifa.mem_wr}, 32'b100);
    chk("call_c3_sp",    ifa.sp,        32'h000F_FFFD);
    chk("call_c3_step",  ifa.step,      32'd0);
    $display("txn CALL pc=00012345 sp=%h", ifa.sp);
    tick();
    chk("call_idle",     {ifa.done, ifa.busy}, 32'b00);

    // RET right after the CALL
    go_a(2'b10, 32'h0, 3'b000);
    chk("ret_c1_rd",     {ifa.mem_rd, ifa.mem_wr}, 32'b10);
    chk("ret_c1_addr",   ifa.mem_addr,  32'h000F_FFFE);
    chk("ret_c1_step",   ifa.step,      32'd2);
    tick();
    chk("ret_c2_addr",   ifa.mem_addr,  32'h000F_FFFF);
    chk("ret_c2_step",   ifa.step,      32'd1);
    tick();
    chk("ret_c3_cap",    {ifa.mem_rd, ifa.done}, 32'b00);
    chk("ret_c3_step",   ifa.step,      32'd0);
    chk("ret_c3_pclo",   ifa.pc_out,    32'h0000_2345);
    tick();
    chk("ret_c4_pulse",  {ifa.done, ifa.pc_load, ifa.flags_load}, 32'b110);
    chk("ret_c4_pc",     ifa.pc_out,    32'h0001_2345);
    chk("ret_c4_sp",     ifa.sp,        32'h000F_FFFF);
    $display("txn RET pc_out=%h sp=%h", ifa.pc_out, ifa.sp);
    tick();
    chk("ret_hold",      {ifa.pc_load, ifa.done, ifa.pc_out}, {2'b00, 32'h0001_2345});

    // INT flags=101 pc=ABCD_0010
    go_a(2'b01, 32'hABCD_0010, 3'b101);
    chk("int_c1_step",   ifa.step,      32'd3);
    chk("int_c1_wr",     {ifa.mem_addr, ifa.mem_wdata}, {32'h000F_FFFF, 16'h0005});
    tick();
    chk("int_c2_wr",     {ifa.mem_addr, ifa.mem_wdata}, {32'h000F_FFFE, 16'hABCD});
    tick();
    chk("int_c3_wr",     {ifa.mem_addr, ifa.mem_wdata}, {32'h000F_FFFD, 16'h0010});
    chk("int_c3_step",   ifa.step,      32'd1);
    tick();
    chk("int_c4_done",   {ifa.done, ifa.pc_load}, 32'b10);
    chk("int_c4_sp",     ifa.sp,        32'h000F_FFFC);
    chk("int_pc_kept",   ifa.pc_out,    32'h0001_2345);
    $display("txn INT pc=abcd0010 flags=101 sp=%h", ifa.sp);
    tick();

    // RTI
    go_a(2'b11, 32'h0, 3'b000);
    chk("rti_c1",        {ifa.mem_rd, ifa.step, ifa.mem_addr}, {1'b1, 2'd3, 32'h000F_FFFD});
    tick();
    chk("rti_c2",        {ifa.mem_rd, ifa.step, ifa.mem_addr}, {1'b1, 2'd2, 32'h000F_FFFE});
    tick();
    chk("rti_c3",        {ifa.mem_rd, ifa.step, ifa.mem_addr}, {1'b1, 2'd1, 32'h000F_FFFF});
    tick();
    chk("rti_c4",        {ifa.mem_rd, ifa.step, ifa.done}, 32'b0);
    tick();
    chk("rti_c5_pulse",  {ifa.done, ifa.pc_load, ifa.flags_load}, 32'b111);
    chk("rti_c5_pc",     ifa.pc_out,    32'hABCD_0010);
    chk("rti_c5_flags",  ifa.flags_out, 32'h5);
    chk("rti_c5_sp",     ifa.sp,        32'h000F_FFFF);
    $display("txn RTI pc_out=%h flags_out=%h sp=%h", ifa.pc_out, ifa.flags_out, ifa.sp);
    tick();

    // CALL with start=RET held on every cycle
    ifa.start = 1'b1; ifa.op = 2'b00; ifa.pc_in = 32'h00C0_FFEE;
    tick();
    ifa.op = 2'b10;
    chk("hold_c1",       {ifa.done, ifa.mem_wr, ifa.step}, {1'b0, 1'b1, 2'd2});
    tick();
    chk("hold_c2",       {ifa.done, ifa.mem_wr, ifa.step}, {1'b0, 1'b1, 2'd1});
    tick();
    chk("hold_c3_done",  {ifa.done, ifa.busy, ifa.mem_rd}, 32'b110);
    tick();
    ifa.start = 1'b0;
    chk("hold_idle",     {ifa.done, ifa.busy}, 32'b00);
    chk("hold_sp",       ifa.sp,        32'h000F_FFFD);
    chk("hold_flags",    ifa.flags_out, 32'h5);
    $display("txn CALL(held start) pc=00c0ffee sp=%h", ifa.sp);
    tick();
    go_a(2'b10, 32'h0, 3'b000);
    tick();
    tick();
    tick();
    chk("hold_ret_pc",   ifa.pc_out,    32'h00C0_FFEE);
    chk("hold_ret_done", {ifa.done, ifa.pc_load}, 32'b11);
    chk("hold_ret_sp",   ifa.sp,        32'h000F_FFFF);
    $display("txn RET pc_out=%h sp=%h", ifa.pc_out, ifa.sp);
    tick();

    // Reset during POP_H of an RTI
    go_a(2'b11, 32'h0, 3'b000);
    tick();
    chk("abort_poph",    {ifa.mem_rd, ifa.step}, {1'b1, 2'd2});
    #2 rst_a = 1'b1;
    #1;
    chk("abort_clear",   {ifa.busy, ifa.mem_rd, ifa.step, ifa.done, ifa.pc_load}, 32'h0);
    chk("abort_sp",      ifa.sp,        32'h000F_FFFF);
    chk("abort_pc",      ifa.pc_out,    32'h0);
    tick();
    chk("abort_nodone",  {ifa.done, ifa.pc_load, ifa.flags_load}, 32'b0);
    rst_a = 1'b0;
    $display("txn RTI aborted by reset sp=%h", ifa.sp);
    tick();
    go_a(2'b00, 32'h1234_5678, 3'b000);
    chk("post_c1_wdata", ifa.mem_wdata, 32'h1234);
    tick();
    chk("post_c2_wdata", ifa.mem_wdata, 32'h5678);
    tick();
    chk("post_c3",       {ifa.done, ifa.sp}, {1'b1, 32'h000F_FFFD});
    $display("txn CALL pc=12345678 sp=%h", ifa.sp);
    tick();

    // Wrap with SP_INIT=0
    rst_b = 1'b0;
    tick();
    chk("wrap_rst_sp",   ifb.sp,        32'h0);
    go_b(2'b00, 32'h0001_2345);
    chk("wrap_c1",       {ifb.mem_addr, ifb.mem_wdata}, {32'h0000_0000, 16'h0001});
    tick();
    chk("wrap_c2",       {ifb.mem_addr, ifb.mem_wdata}, {32'hFFFF_FFFF, 16'h2345});
    tick();
    chk("wrap_call_sp",  ifb.sp,        32'hFFFF_FFFE);
    $display("txn CALL(wrap) sp=%h", ifb.sp);
    tick();
    go_b(2'b10, 32'h0);
    chk("wrap_r1_addr",  ifb.mem_addr,  32'hFFFF_FFFF);
    tick();
    chk("wrap_r2_addr",  ifb.mem_addr,  32'h0000_0000);
    tick();
    tick();
    chk("wrap_ret_pc",   ifb.pc_out,    32'h0001_2345);
    chk("wrap_ret_sp",   {ifb.done, ifb.sp}, {1'b1, 32'h0});
    $display("txn RET(wrap) pc_out=%h sp=%h", ifb.pc_out, ifb.sp);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
